bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Arbitrates a single shared memory port between the instruction-fetch bus (ibus) and the load/store data bus (dbus). Both requesters use the level-request / single-pulse-ack protocol. The block sits between the pipeline's bus masters and the memory/peripheral slave. It keeps one transaction outstanding at a time and raises per-master stall requests toward the pipeline controller.

## Interface
Parameters:
- MAX_D_STREAK, 4: maximum consecutive dbus grants while ibus is waiting before ibus is forced through (range 1–15).
- TIMEOUT_CYCLES, 255: watchdog limit in cycles, used only with ARB_TIMEOUT_EN (range 1–255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- I_ibus_req / I_ibus_we  in  1 / 1  ibus request level and write enable.
- I_ibus_addr / I_ibus_wdata  in  32 / 32  ibus address and write data.
- I_ibus_mask  in  4  ibus byte mask.
- O_ibus_ack  out  1  one-cycle completion pulse for ibus.
- O_ibus_rdata  out  32  ibus read data, valid with O_ibus_ack.
- O_ibus_stallreq  out  1  equals I_ibus_req & ~O_ibus_ack.
- I_dbus_req, I_dbus_we, I_dbus_addr, I_dbus_wdata, I_dbus_mask, O_dbus_ack, O_dbus_rdata, O_dbus_stallreq: dbus equivalents, same directions and widths.
- O_mem_req / O_mem_we  out  1 / 1  slave request and write enable.
- O_mem_addr / O_mem_wdata  out  32 / 32  slave address and write data.
- O_mem_mask  out  4  slave byte mask.
- I_mem_ack  in  1  slave completion pulse; read data is valid in the same cycle.
- I_mem_rdata  in  32  slave read data.
- O_bus_err  out  1  timeout pulse; present only with ARB_TIMEOUT_EN, otherwise tied to 0.

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE, arbitration:
  - Default priority is dbus over ibus.
  - If both request and d_streak == MAX_D_STREAK, ibus wins.
  - The winner's we/addr/wdata/mask are latched into command registers, and the FSM moves to BUSY_I or BUSY_D.
- BUSY_x:
  - O_mem_req = 1 and O_mem_* are driven from the latched command; they are stable for the whole transaction.
  - On I_mem_ack: O_x_ack = 1 and O_x_rdata = I_mem_rdata, both combinational pass-through. The next state is IDLE.
- A requester holds req and its fields stable until its ack. A request deasserted before ack is protocol misuse and is not checked.
- I_mem_ack in IDLE is ignored; this covers a stale ack after a timeout.
- d_streak (4 bits):
  - increments on a dbus grant while I_ibus_req = 1, saturating at MAX_D_STREAK;
  - clears on an ibus grant, or in any IDLE cycle with I_ibus_req = 0.
- O_x_rdata is 0 whenever O_x_ack = 0.
- The non-selected master's ack is always 0.

## Timing
- Reset: state = IDLE, d_streak = 0, and all command registers are 0. All outputs are 0, including O_mem_req, both acks, both rdata, and O_bus_err. Each stallreq follows its input request.
- Latency: a request sampled in IDLE at edge n gives O_mem_req = 1 from cycle n+1.
  - With a zero-wait slave (ack in the first BUSY cycle), the master ack arrives in cycle n+1. Each transaction therefore takes 2 cycles, and sustained throughput is 1 transaction per 2 cycles.
  - Each slave wait cycle adds 1 cycle.
- Simultaneous new requests in IDLE: one grant per IDLE cycle. The loser stays pending, and its stallreq stays high.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately and the transaction is dropped with no ack. The slave must also be reset.

## Configuration
- ARB_TIMEOUT_EN defined:
  - An 8-bit watchdog counts cycles spent in BUSY_x.
  - When the count reaches TIMEOUT_CYCLES without I_mem_ack, the block:
    - pulses O_x_ack with O_x_rdata = 32'hDEAD_BEEF;
    - pulses O_bus_err for one cycle;
    - drops O_mem_req and returns to IDLE.
  - The counter clears on entry to BUSY.
  - If the ack and the timeout land in the same cycle, the ack wins: real data is returned and there is no error.
- ARB_TIMEOUT_EN undefined: no watchdog is built, O_bus_err is a constant 0, and BUSY waits indefinitely.

## Structure
- defines.v: state encodings (ArbIdle, ArbBusyI, ArbBusyD), the DeadData constant 32'hDEADBEEF, and the existing InstAddrBus, InstBus and DBUS_MASK widths.
- Sub-module bus_arb_pick: combinational grant selection from (ibus_req, dbus_req, d_streak == MAX_D_STREAK). It outputs grant_i and grant_d (one-hot or none) and is instantiated once.

## Test plan
- Single ibus read, addr 0x8000_0000, zero-wait slave with rdata 0x0000_0013 -> O_mem_req at cycle 1 and O_ibus_ack at cycle 1 with rdata 0x13; O_ibus_stallreq is high in cycle 0 only.
- ibus and dbus requesting in the same cycle, dbus write 0x1234_5678 to 0x8000_1000 with mask 4'b0011 -> dbus served first with O_mem_we = 1 and the mask passed through; ibus is served in the next IDLE-to-BUSY cycle.
- dbus held continuously and ibus pending, MAX_D_STREAK = 4 -> 4 dbus grants, then an ibus grant, then dbus resumes.
- Slave with 3 wait states -> O_mem_req high for 4 cycles with address stable, a single ack pulse, and no second grant during BUSY.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8, slave never acks -> after 8 BUSY cycles, O_dbus_ack = 1 with rdata 0xDEADBEEF and O_bus_err = 1. A later stray I_mem_ack in IDLE produces no ack.
- rst driven low during BUSY_D with a 3-wait slave -> next cycle all outputs are 0 and no ack is produced. After release, a new ibus request completes normally.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the ibus/dbus memory-port arbiter.
package bus_arbiter_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;
    localparam int DBUS_MASK   = 4;

    localparam logic [InstBus-1:0] DeadData = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ArbIdle  = 2'd0,
        ArbBusyI = 2'd1,
        ArbBusyD = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                   we;
        logic [InstAddrBus-1:0] addr;
        logic [InstBus-1:0]     wdata;
        logic [DBUS_MASK-1:0]   mask;
    } bus_cmd_t;

endpackage

// File: rtl/bus_arb_pick.sv
// Grant selection: dbus first, ibus forced through once the dbus streak is full.
module bus_arb_pick (
    input  logic ibus_req,
    input  logic dbus_req,
    input  logic streak_full,
    output logic grant_i,
    output logic grant_d
);

    assign grant_i = ibus_req & (~dbus_req | streak_full);
    assign grant_d = dbus_req & ~grant_i;

endmodule

// File: rtl/bus_arbiter.sv
// Single-outstanding arbiter of ibus/dbus onto one memory port.
// Optional watchdog built when ARB_TIMEOUT_EN is defined.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int MAX_D_STREAK   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        I_ibus_req,
    input  logic        I_ibus_we,
    input  logic [31:0] I_ibus_addr,
    input  logic [31:0] I_ibus_wdata,
    input  logic [3:0]  I_ibus_mask,
    output logic        O_ibus_ack,
    output logic [31:0] O_ibus_rdata,
    output logic        O_ibus_stallreq,
    input  logic        I_dbus_req,
    input  logic        I_dbus_we,
    input  logic [31:0] I_dbus_addr,
    input  logic [31:0] I_dbus_wdata,
    input  logic [3:0]  I_dbus_mask,
    output logic        O_dbus_ack,
    output logic [31:0] O_dbus_rdata,
    output logic        O_dbus_stallreq,
    output logic        O_mem_req,
    output logic        O_mem_we,
    output logic [31:0] O_mem_addr,
    output logic [31:0] O_mem_wdata,
    output logic [3:0]  O_mem_mask,
    input  logic        I_mem_ack,
    input  logic [31:0] I_mem_rdata,
    output logic        O_bus_err
);

    if (MAX_D_STREAK < 1 || MAX_D_STREAK > 15) begin : g_bad_streak
        $error("MAX_D_STREAK out of range 1..15");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 1..255");
    end

    localparam logic [3:0] StreakMax = 4'(MAX_D_STREAK);

    arb_state_t state, state_nxt;
    bus_cmd_t   cmd, cmd_nxt;
    logic [3:0] d_streak, d_streak_nxt;
    logic       idle, busy, streak_full;
    logic       pick_i, pick_d, grant_i, grant_d;
    logic       timeout, done;
    logic [31:0] rdata_sel;

    assign idle        = (state == ArbIdle);
    assign busy        = ~idle;
    assign streak_full = (d_streak == StreakMax);

    bus_arb_pick u_pick (
        .ibus_req    (I_ibus_req),
        .dbus_req    (I_dbus_req),
        .streak_full (streak_full),
        .grant_i     (pick_i),
        .grant_d     (pick_d)
    );

    assign grant_i = idle & pick_i;
    assign grant_d = idle & pick_d;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] WdLast = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wd_cnt;

    // Held at zero while idle, so it always starts fresh on BUSY entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt <= '0;
        end else if (idle) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 8'd1;
        end
    end

    assign timeout   = busy & (wd_cnt == WdLast);
    assign O_bus_err = timeout & ~I_mem_ack;
`else
    assign timeout   = 1'b0;
    assign O_bus_err = 1'b0;
`endif

    // A real ack beats a same-cycle timeout.
    assign done      = busy & (I_mem_ack | timeout);
    assign rdata_sel = I_mem_ack ? I_mem_rdata : DeadData;

    assign O_ibus_ack   = (state == ArbBusyI) & done;
    assign O_dbus_ack   = (state == ArbBusyD) & done;
    assign O_ibus_rdata = O_ibus_ack ? rdata_sel : '0;
    assign O_dbus_rdata = O_dbus_ack ? rdata_sel : '0;

    assign O_ibus_stallreq = I_ibus_req & ~O_ibus_ack;
    assign O_dbus_stallreq = I_dbus_req & ~O_dbus_ack;

    assign O_mem_req   = busy;
    assign O_mem_we    = cmd.we;
    assign O_mem_addr  = cmd.addr;
    assign O_mem_wdata = cmd.wdata;
    assign O_mem_mask  = cmd.mask;

    always_comb begin
        state_nxt    = state;
        cmd_nxt      = cmd;
        d_streak_nxt = d_streak;
        unique case (state)
            ArbIdle: begin
                if (grant_i) begin
                    state_nxt    = ArbBusyI;
                    cmd_nxt      = '{we: I_ibus_we, addr: I_ibus_addr,
                                     wdata: I_ibus_wdata, mask: I_ibus_mask};
                    d_streak_nxt = '0;
                end else if (grant_d) begin
                    state_nxt = ArbBusyD;
                    cmd_nxt   = '{we: I_dbus_we, addr: I_dbus_addr,
                                  wdata: I_dbus_wdata, mask: I_dbus_mask};
                    if (I_ibus_req && !streak_full) begin
                        d_streak_nxt = d_streak + 4'd1;
                    end
                end
                if (!I_ibus_req) begin
                    d_streak_nxt = '0;
                end
            end
            ArbBusyI, ArbBusyD: begin
                if (done) begin
                    state_nxt = ArbIdle;
                end
            end
            default: state_nxt = ArbIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ArbIdle;
            cmd      <= '0;
            d_streak <= '0;
        end else begin
            state    <= state_nxt;
            cmd      <= cmd_nxt;
            d_streak <= d_streak_nxt;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus random traffic.
module tb_bus_arbiter;

    localparam int MAXS = 4;
`ifdef ARB_TIMEOUT_EN
    localparam int TO    = 8;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TO    = 255;
    localparam bit TO_EN = 1'b0;
`endif
    localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        I_ibus_req = 0, I_ibus_we = 0;
    logic [31:0] I_ibus_addr = 0, I_ibus_wdata = 0;
    logic [3:0]  I_ibus_mask = 0;
    logic        O_ibus_ack, O_ibus_stallreq;
    logic [31:0] O_ibus_rdata;
    logic        I_dbus_req = 0, I_dbus_we = 0;
    logic [31:0] I_dbus_addr = 0, I_dbus_wdata = 0;
    logic [3:0]  I_dbus_mask = 0;
    logic        O_dbus_ack, O_dbus_stallreq;
    logic [31:0] O_dbus_rdata;
    logic        O_mem_req, O_mem_we;
    logic [31:0] O_mem_addr, O_mem_wdata;
    logic [3:0]  O_mem_mask;
    logic        I_mem_ack = 0;
    logic [31:0] I_mem_rdata = 0;
    logic        O_bus_err;

    always #5 clk = ~clk;

    bus_arbiter #(.MAX_D_STREAK(MAXS), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .I_ibus_req(I_ibus_req), .I_ibus_we(I_ibus_we),
        .I_ibus_addr(I_ibus_addr), .I_ibus_wdata(I_ibus_wdata),
        .I_ibus_mask(I_ibus_mask), .O_ibus_ack(O_ibus_ack),
        .O_ibus_rdata(O_ibus_rdata), .O_ibus_stallreq(O_ibus_stallreq),
        .I_dbus_req(I_dbus_req), .I_dbus_we(I_dbus_we),
        .I_dbus_addr(I_dbus_addr), .I_dbus_wdata(I_dbus_wdata),
        .I_dbus_mask(I_dbus_mask), .O_dbus_ack(O_dbus_ack),
        .O_dbus_rdata(O_dbus_rdata), .O_dbus_stallreq(O_dbus_stallreq),
        .O_mem_req(O_mem_req), .O_mem_we(O_mem_we),
        .O_mem_addr(O_mem_addr), .O_mem_wdata(O_mem_wdata),
        .O_mem_mask(O_mem_mask), .I_mem_ack(I_mem_ack),
        .I_mem_rdata(I_mem_rdata), .O_bus_err(O_bus_err)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: owner 0=none 1=ibus 2=dbus, busy cycles elapsed
    int          m_own = 0, m_streak = 0, m_wait = 0;
    logic        m_we = 0;
    logic [31:0] m_addr = 0, m_wdata = 0;
    logic [3:0]  m_mask = 0;
    logic        e_iack, e_dack;

    task automatic sample();
        logic done, to_hit;
        logic [31:0] rd;
        int w;
        @(negedge clk);
        if (!rst) begin
            m_own = 0; m_streak = 0; m_wait = 0;
            m_we = 0; m_addr = 0; m_wdata = 0; m_mask = 0;
            chk("rst_addr", O_mem_addr, 0);
            chk("rst_wdata", O_mem_wdata, 0);
            chk("rst_we", O_mem_we, 0);
            chk("rst_mask", O_mem_mask, 0);
        end
        to_hit = TO_EN && m_own != 0 && m_wait == TO - 1;
        done   = m_own != 0 && (I_mem_ack || to_hit);
        e_iack = m_own == 1 && done;
        e_dack = m_own == 2 && done;
        rd     = I_mem_ack ? I_mem_rdata : DEAD;
        chk("mem_req", O_mem_req, m_own != 0);
        if (m_own != 0) begin
            chk("mem_we", O_mem_we, m_we);
            chk("mem_addr", O_mem_addr, m_addr);
            chk("mem_wdata", O_mem_wdata, m_wdata);
            chk("mem_mask", O_mem_mask, m_mask);
        end
        chk("ibus_ack", O_ibus_ack, e_iack);
        chk("dbus_ack", O_dbus_ack, e_dack);
        chk("ibus_rdata", O_ibus_rdata, e_iack ? rd : 32'd0);
        chk("dbus_rdata", O_dbus_rdata, e_dack ? rd : 32'd0);
        chk("ibus_stall", O_ibus_stallreq, I_ibus_req & ~e_iack);
        chk("dbus_stall", O_dbus_stallreq, I_dbus_req & ~e_dack);
        chk("bus_err", O_bus_err, to_hit && !I_mem_ack);
        if (rst) begin
            if (m_own == 0) begin
                w = 0;
                if (I_ibus_req && I_dbus_req) w = (m_streak == MAXS) ? 1 : 2;
                else if (I_ibus_req) w = 1;
                else if (I_dbus_req) w = 2;
                if (w == 1) begin
                    m_streak = 0;
                    m_we = I_ibus_we; m_addr = I_ibus_addr;
                    m_wdata = I_ibus_wdata; m_mask = I_ibus_mask;
                end else if (w == 2) begin
                    if (I_ibus_req) m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
                    m_we = I_dbus_we; m_addr = I_dbus_addr;
                    m_wdata = I_dbus_wdata; m_mask = I_dbus_mask;
                end
                if (!I_ibus_req) m_streak = 0;
                m_own = w;
                m_wait = 0;
            end else if (done) begin
                m_own = 0;
            end else begin
                m_wait++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        I_ibus_req = 0; I_ibus_we = 0; I_ibus_addr = 0;
        I_ibus_wdata = 0; I_ibus_mask = 0;
        I_dbus_req = 0; I_dbus_we = 0; I_dbus_addr = 0;
        I_dbus_wdata = 0; I_dbus_mask = 0;
        I_mem_ack = 0; I_mem_rdata = 0;
    endtask

    initial begin
        int seq[$];
        int n_req, n_dack, sw, ok;
        logic i_pend, d_pend;

        // Reset: outputs quiet, stallreq follows the raw request
        quiet();
        rst = 0;
        #2;
        I_ibus_req = 1;
        sample();
        chk("rst_istall", O_ibus_stallreq, 1);
        tick();
        quiet();
        rst = 1;
        sample(); tick();

        // Single zero-wait ibus read
        I_ibus_req = 1; I_ibus_addr = 32'h8000_0000;
        sample();
        chk("t1_c0_req", O_mem_req, 0);
        chk("t1_c0_stall", O_ibus_stallreq, 1);
        tick();
        I_mem_ack = 1; I_mem_rdata = 32'h13;
        sample();
        chk("t1_c1_req", O_mem_req, 1);
        chk("t1_addr", O_mem_addr, 32'h8000_0000);
        chk("t1_ack", O_ibus_ack, 1);
        chk("t1_rdata", O_ibus_rdata, 32'h13);
        chk("t1_c1_stall", O_ibus_stallreq, 0);
        tick();
        quiet();
        sample(); tick();

        // Simultaneous requests: dbus write first, then ibus
        I_mem_ack = 1; I_mem_rdata = 32'hAA55_0001;
        I_ibus_req = 1; I_ibus_addr = 32'h8000_0004;
        I_dbus_req = 1; I_dbus_we = 1; I_dbus_addr = 32'h8000_1000;
        I_dbus_wdata = 32'h1234_5678; I_dbus_mask = 4'b0011;
        sample(); tick();
        sample();
        chk("t2_dack", O_dbus_ack, 1);
        chk("t2_no_iack", O_ibus_ack, 0);
        chk("t2_we", O_mem_we, 1);
        chk("t2_mask", O_mem_mask, 4'b0011);
        chk("t2_wdata", O_mem_wdata, 32'h1234_5678);
        chk("t2_istall", O_ibus_stallreq, 1);
        tick();
        I_dbus_req = 0;
        sample(); tick();
        sample();
        chk("t2_iack", O_ibus_ack, 1);
        chk("t2_iaddr", O_mem_addr, 32'h8000_0004);
        tick();
        quiet();
        sample(); tick();

        // dbus held, ibus pending: streak forces ibus after MAXS grants
        I_mem_ack = 1;
        I_dbus_req = 1; I_dbus_addr = 32'h8000_2000;
        I_ibus_req = 1; I_ibus_addr = 32'h8000_0100;
        for (int c = 0; c < 14; c++) begin
            sample();
            if (O_dbus_ack) seq.push_back(2);
            if (O_ibus_ack) seq.push_back(1);
            if (e_iack) I_ibus_req = 0;
            tick();
        end
        chk("t3_count", seq.size() >= MAXS + 2, 1);
        for (int k = 0; k < MAXS + 2 && k < seq.size(); k++)
            chk($sformatf("t3_seq%0d", k), seq[k], (k == MAXS) ? 1 : 2);
        quiet();
        sample(); tick();

        // Three-wait slave: four request cycles, one ack, ibus waits
        I_dbus_req = 1; I_dbus_addr = 32'h8000_3000; I_dbus_mask = 4'hF;
        I_ibus_req = 1; I_ibus_addr = 32'h8000_0200;
        n_req = 0; n_dack = 0; ok = 0;
        for (int c = 0; c < 12 && !ok; c++) begin
            I_mem_ack = (m_own == 2 && m_wait == 3);
            I_mem_rdata = 32'h0BAD_F00D;
            sample();
            if (O_mem_req) begin
                n_req++;
                chk("t4_addr", O_mem_addr, 32'h8000_3000);
            end
            if (O_dbus_ack) n_dack++;
            if (e_dack) begin ok = 1; I_dbus_req = 0; end
            tick();
        end
        chk("t4_done", ok, 1);
        chk("t4_req_cycles", n_req, 4);
        chk("t4_acks", n_dack, 1);
        I_dbus_req = 0; I_mem_ack = 1;
        for (int c = 0; c < 3; c++) begin
            sample();
            if (e_iack) I_ibus_req = 0;
            tick();
        end
        quiet();
        sample(); tick();

`ifdef ARB_TIMEOUT_EN
        // Silent slave: watchdog answers with DEAD data and an error
        I_dbus_req = 1; I_dbus_addr = 32'h8000_4000;
        n_req = 0; ok = 0;
        for (int c = 0; c < 20 && !ok; c++) begin
            sample();
            if (O_mem_req) n_req++;
            if (O_dbus_ack) begin
                ok = 1;
                chk("t5_rdata", O_dbus_rdata, DEAD);
                chk("t5_err", O_bus_err, 1);
                chk("t5_busy_cycles", n_req, TO);
            end
            tick();
        end
        chk("t5_done", ok, 1);
        I_dbus_req = 0;
        sample(); tick();
        I_mem_ack = 1; I_mem_rdata = 32'h7777_7777;
        sample();
        chk("t5_stray_dack", O_dbus_ack, 0);
        chk("t5_stray_err", O_bus_err, 0);
        tick();
        quiet();
`endif

        // Reset in the middle of a dbus transaction
        I_dbus_req = 1; I_dbus_addr = 32'h8000_5000; I_dbus_we = 1;
        I_dbus_wdata = 32'hCAFE_0000;
        sample(); tick();
        sample(); tick();
        rst = 0;
        sample();
        chk("t6_req", O_mem_req, 0);
        chk("t6_dack", O_dbus_ack, 0);
        chk("t6_addr", O_mem_addr, 0);
        tick();
        quiet();
        sample(); tick();
        rst = 1;
        sample(); tick();
        I_ibus_req = 1; I_ibus_addr = 32'h8000_0300;
        sample(); tick();
        I_mem_ack = 1; I_mem_rdata = 32'h0000_0093;
        sample();
        chk("t6_iack", O_ibus_ack, 1);
        chk("t6_irdata", O_ibus_rdata, 32'h93);
        tick();
        quiet();
        sample(); tick();

        // Random traffic
        i_pend = 0; d_pend = 0; sw = 0;
        for (int c = 0; c < 800; c++) begin
            if (!i_pend && $urandom_range(2) == 0) begin
                i_pend = 1;
                I_ibus_we = 1'($urandom); I_ibus_addr = $urandom;
                I_ibus_wdata = $urandom; I_ibus_mask = 4'($urandom);
            end
            if (!d_pend && $urandom_range(1) == 0) begin
                d_pend = 1;
                I_dbus_we = 1'($urandom); I_dbus_addr = $urandom;
                I_dbus_wdata = $urandom; I_dbus_mask = 4'($urandom);
            end
            I_ibus_req = i_pend;
            I_dbus_req = d_pend;
            if (m_own == 0) begin
                sw = $urandom_range(3);
                I_mem_ack = ($urandom_range(5) == 0);
            end else begin
                I_mem_ack = (m_wait >= sw);
            end
            I_mem_rdata = $urandom;
            sample();
            if (e_iack) i_pend = 0;
            if (e_dack) d_pend = 0;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
